xbar_input_queue: RTL and testbench

- Per-input-port flit queue directly upstream of the 1-to-6 crossbar demux wrapper.
- Accepts flits tagged with a 3-bit output-port select and stores them in a DEPTH-entry FIFO.
- Presents the head flit as din/sel to the demux, and holds it until the selected output port signals ready.
- Forces din to all-zero when empty, so every demux output idles at zero.

---
 rtl/xbar_input_queue.sv | 106 ++++++++++
 tb/tb_xbar_input_queue.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xbar_input_queue.sv
// Per-input-port flit queue feeding the 1-to-6 crossbar demux.
// In-order FIFO with head-of-line blocking, illegal-select drop counting and a sticky error flag.
`ifndef WIDTH_XBAR
`define WIDTH_XBAR 8
`endif

module xbar_input_queue #(
  parameter int WIDTH = `WIDTH_XBAR,
  parameter int DEPTH = 4,
  parameter int CNTW  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in_flit,
  input  logic [2:0]               in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [5:0]               port_ready,
  output logic [WIDTH-1:0]         din,
  output logic [2:0]               sel,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNTW-1:0]          drop_cnt,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [AW:0]      count_reg, count_next;
  logic [CNTW-1:0]  drop_cnt_reg, drop_cnt_next;
  logic             err_reg, err_next;

  logic [WIDTH-1:0] flit_mem [DEPTH];
  logic [2:0]       sel_mem  [DEPTH];

  logic [WIDTH-1:0] head_flit;
  logic [2:0]       head_sel;
  logic [7:0]       ready_pad;
  logic             accept, legal, push, drop, pop;

  assign head_flit = flit_mem[rd_ptr_reg];
  assign head_sel  = sel_mem[rd_ptr_reg];
  // Padding lets a 3-bit select index safely; legal entries never exceed 5.
  assign ready_pad = {2'b00, port_ready};

  assign out_valid = (count_reg != '0);
  assign in_ready  = !reset && (count_reg != FULL_COUNT);
  assign accept    = in_valid && in_ready;
  assign legal     = (in_sel <= 3'd5);
  assign push      = accept && legal;
  assign drop      = accept && !legal;
  assign pop       = out_valid && ready_pad[head_sel];

  assign din       = out_valid ? head_flit : '0;
  assign sel       = out_valid ? head_sel  : '0;
  assign occupancy = count_reg;
  assign drop_cnt  = drop_cnt_reg;
  assign err       = err_reg;

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    drop_cnt_next = drop_cnt_reg;
    err_next      = err_reg;
    if (push) wr_ptr_next = wr_ptr_reg + AW'(1);
    if (pop)  rd_ptr_next = rd_ptr_reg + AW'(1);
    case ({push, pop})
      2'b10:   count_next = count_reg + (AW+1)'(1);
      2'b01:   count_next = count_reg - (AW+1)'(1);
      default: count_next = count_reg;
    endcase
    if (drop) begin
      err_next = 1'b1;
      if (drop_cnt_reg != {CNTW{1'b1}}) drop_cnt_next = drop_cnt_reg + CNTW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      drop_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      drop_cnt_reg <= drop_cnt_next;
      err_reg      <= err_next;
    end
  end

  // Entry contents need no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      flit_mem[wr_ptr_reg] <= in_flit;
      sel_mem[wr_ptr_reg]  <= in_sel;
    end
  end

endmodule

// File: tb/tb_xbar_input_queue.sv
// Scenario bench for xbar_input_queue: a queue scoreboard tracks accepted flits and
// is compared with the head presented by the DUT.
module tb_xbar_input_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_flit;
  logic [2:0] in_sel;
  logic       in_valid;
  logic [5:0] port_ready;
  logic       in_ready;
  logic [7:0] din;
  logic [2:0] sel;
  logic       out_valid;
  logic [2:0] occupancy;
  logic [7:0] drop_cnt;
  logic       err;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {logic [7:0] f; logic [2:0] s;} ent_t;
  ent_t sb[$];
  int   exp_drop = 0;

  xbar_input_queue #(.WIDTH(8), .DEPTH(4), .CNTW(8)) dut (
    .clk(clk), .reset(reset), .in_flit(in_flit), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .port_ready(port_ready), .din(din), .sel(sel),
    .out_valid(out_valid), .occupancy(occupancy), .drop_cnt(drop_cnt), .err(err)
  );

  always #5 clk = ~clk;

  // Advance one clock, updating the scoreboard from the stimulus seen at the edge.
  task automatic cycle();
    bit do_push, do_pop;
    do_push = in_valid && !reset && sb.size() < 4 && in_sel <= 3'd5;
    do_pop  = !reset && sb.size() > 0 && port_ready[sb[0].s];
    if (in_valid && !reset && sb.size() < 4 && in_sel > 3'd5 && exp_drop < 255) exp_drop++;
    @(posedge clk); #1;
    if (do_pop) void'(sb.pop_front());
    if (do_push) sb.push_back({in_flit, in_sel});
  endtask

  task automatic test_reset();
    reset = 1'b1; in_flit = '0; in_sel = '0; in_valid = 1'b0; port_ready = '0;
    repeat (3) begin @(posedge clk); end
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || din !== 8'h00 || sel !== 3'd0 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got v=%b din=%0h sel=%0d rdy=%b expected 0/0/0/0", out_valid, din, sel, in_ready);
    end
    tests_run++;
    if (occupancy !== 3'd0 || drop_cnt !== 8'd0 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: got occ=%0d drop=%0d err=%b expected 0/0/0", occupancy, drop_cnt, err);
    end
    reset = 1'b0;
    sb.delete(); exp_drop = 0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release_ready: got %b expected 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    in_flit = 8'h5A; in_sel = 3'd3; in_valid = 1'b1; port_ready = '0;
    cycle();
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || din !== 8'h5A || sel !== 3'd3 || occupancy !== 3'd1) begin
      tests_failed++;
      $display("FAIL single_head: got v=%b din=%0h sel=%0d occ=%0d expected 1/5a/3/1", out_valid, din, sel, occupancy);
    end
    port_ready = 6'b001000;
    cycle();
    tests_run++;
    if (out_valid !== 1'b0 || din !== 8'h00 || sel !== 3'd0 || occupancy !== 3'd0) begin
      tests_failed++;
      $display("FAIL single_pop: got v=%b din=%0h sel=%0d occ=%0d expected 0/0/0/0", out_valid, din, sel, occupancy);
    end
    port_ready = '0;
  endtask

  task automatic drain(string name);
    port_ready = 6'b111111; in_valid = 1'b0;
    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      tests_run++;
      if (din !== sb[0].f || sel !== sb[0].s) begin
        tests_failed++;
        $display("FAIL %s_order: got din=%0h sel=%0d expected din=%0h sel=%0d", name, din, sel, sb[0].f, sb[0].s);
      end
      cycle();
    end
    tests_run++;
    if (sb.size() != 0 || occupancy !== 3'd0) begin
      tests_failed++;
      $display("FAIL %s_empty: got occ=%0d expected 0 (model %0d left)", name, occupancy, sb.size());
    end
    port_ready = '0;
  endtask

  task automatic test_fill_stall();
    port_ready = '0;
    for (int i = 0; i < 4; i++) begin
      in_flit = 8'h10 + 8'(i); in_sel = 3'(i); in_valid = 1'b1;
      cycle();
    end
    tests_run++;
    if (occupancy !== 3'd4 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL fill_full: got occ=%0d rdy=%b expected 4/0", occupancy, in_ready);
    end
    in_flit = 8'hEE; in_sel = 3'd4;
    for (int i = 0; i < 10; i++) begin
      cycle();
      tests_run++;
      if (din !== 8'h10 || sel !== 3'd0 || occupancy !== 3'd4) begin
        tests_failed++;
        $display("FAIL stall_hold: got din=%0h sel=%0d occ=%0d expected 10/0/4", din, sel, occupancy);
      end
    end
    drain("fill");
  endtask

  task automatic test_hol_wrap();
    port_ready = 6'b100000;
    in_valid = 1'b1; in_flit = 8'hA1; in_sel = 3'd2; cycle();
    in_flit = 8'hA2; in_sel = 3'd5; cycle();
    in_valid = 1'b0;
    repeat (3) cycle();
    tests_run++;
    if (occupancy !== 3'd2 || din !== 8'hA1 || sel !== 3'd2) begin
      tests_failed++;
      $display("FAIL hol_block: got occ=%0d din=%0h sel=%0d expected 2/a1/2", occupancy, din, sel);
    end
    port_ready = 6'b000100; cycle();
    tests_run++;
    if (occupancy !== 3'd1 || din !== 8'hA2 || sel !== 3'd5) begin
      tests_failed++;
      $display("FAIL hol_pop_first: got occ=%0d din=%0h sel=%0d expected 1/a2/5", occupancy, din, sel);
    end
    port_ready = 6'b100000; cycle();
    tests_run++;
    if (occupancy !== 3'd0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL hol_pop_second: got occ=%0d v=%b expected 0/0", occupancy, out_valid);
    end
    port_ready = 6'b111111;
    in_valid = 1'b1; in_flit = 8'h30; in_sel = 3'd1; cycle();
    for (int i = 0; i < 12; i++) begin
      in_flit = 8'($urandom); in_sel = 3'($urandom_range(0, 5));
      tests_run++;
      if (sb.size() == 0 || din !== sb[0].f || sel !== sb[0].s || occupancy !== 3'd1) begin
        tests_failed++;
        $display("FAIL wrap_order: got din=%0h sel=%0d occ=%0d expected occ=1 and scoreboard head", din, sel, occupancy);
      end
      cycle();
    end
    drain("wrap");
  endtask

  task automatic test_simul();
    port_ready = '0;
    in_valid = 1'b1; in_flit = 8'hA0; in_sel = 3'd1; cycle();
    in_flit = 8'hB0; in_sel = 3'd4; port_ready = 6'b000010; cycle();
    in_valid = 1'b0; port_ready = '0;
    tests_run++;
    if (occupancy !== 3'd1 || din !== 8'hB0 || sel !== 3'd4) begin
      tests_failed++;
      $display("FAIL simul_occ1: got occ=%0d din=%0h sel=%0d expected 1/b0/4", occupancy, din, sel);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_flit = 8'hC0 + 8'(i); in_sel = 3'(i); cycle();
    end
    in_flit = 8'hDD; in_sel = 3'd0; port_ready = 6'b111111; cycle();
    in_valid = 1'b0; port_ready = '0;
    tests_run++;
    if (occupancy !== 3'd3 || din !== 8'hC0 || occupancy !== 3'(sb.size())) begin
      tests_failed++;
      $display("FAIL simul_full: got occ=%0d din=%0h expected 3/c0", occupancy, din);
    end
    drain("simul");
  endtask

  task automatic test_illegal();
    in_valid = 1'b1; in_flit = 8'h77; in_sel = 3'd6;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL illegal_ready: got %b expected 1", in_ready);
    end
    cycle();
    in_sel = 3'd7; cycle();
    in_valid = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1 || occupancy !== 3'd0 || drop_cnt !== 8'd2 || err !== 1'b1) begin
      tests_failed++;
      $display("FAIL illegal_drop: got rdy=%b occ=%0d drop=%0d err=%b expected 1/0/2/1", in_ready, occupancy, drop_cnt, err);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_sel = (i % 2 == 0) ? 3'd6 : 3'd7; cycle();
    end
    in_valid = 1'b0;
    tests_run++;
    if (drop_cnt !== 8'd255 || 32'(drop_cnt) !== exp_drop || err !== 1'b1) begin
      tests_failed++;
      $display("FAIL illegal_saturate: got drop=%0d err=%b expected 255/1", drop_cnt, err);
    end
  endtask

  task automatic test_async_reset();
    port_ready = '0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_flit = 8'hE0 + 8'(i); in_sel = 3'(i + 1); cycle();
    end
    in_valid = 1'b0;
    tests_run++;
    if (occupancy !== 3'd3) begin
      tests_failed++;
      $display("FAIL areset_setup: got occ=%0d expected 3", occupancy);
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || din !== 8'h00 || occupancy !== 3'd0 || err !== 1'b0 ||
        drop_cnt !== 8'd0 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL areset_immediate: got v=%b din=%0h occ=%0d err=%b drop=%0d rdy=%b expected all 0",
               out_valid, din, occupancy, err, drop_cnt, in_ready);
    end
    sb.delete(); exp_drop = 0;
    @(posedge clk); #1;
    reset = 1'b0; port_ready = 6'b111111;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL areset_release: got rdy=%b expected 1", in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      cycle();
      tests_run++;
      if (out_valid !== 1'b0 || din !== 8'h00 || occupancy !== 3'd0) begin
        tests_failed++;
        $display("FAIL areset_stale: got v=%b din=%0h occ=%0d expected 0/0/0", out_valid, din, occupancy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_stall();
    test_hol_wrap();
    test_simul();
    test_illegal();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
